// File: rtl/soc_bus_fabric.sv
// Address decoder, read-data mux and wait-state generator between a 65xx CPU bus and N slaves.
// Decode is combinational, read data returns one cycle after the accepted address, RDY stalls per-slave.
module soc_bus_fabric #(
  parameter int                       N_SLAVES      = 4,
  parameter int                       AW            = 16,
  parameter int                       DW            = 8,
  parameter logic [N_SLAVES*AW-1:0]   BASE          = {16'hF000, 16'h1040, 16'h1000, 16'h0000},
  parameter logic [N_SLAVES*AW-1:0]   MASK          = {16'hF000, 16'hFFC0, 16'hFFC0, 16'hF000},
  parameter logic [N_SLAVES*4-1:0]    WAIT          = {4'd0, 4'd2, 4'd0, 4'd0},
  parameter logic [DW-1:0]            UNMAPPED_DATA = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          cpu_ab,
  input  logic                   cpu_we_n,
  input  logic [DW-1:0]          cpu_do,
  output logic [DW-1:0]          cpu_di,
  output logic                   cpu_rdy,
  output logic [N_SLAVES-1:0]    s_cs_n,
  output logic                   s_we_n,
  output logic [DW-1:0]          s_wdata,
  input  logic [N_SLAVES*DW-1:0] s_rdata,
  output logic                   bus_err,
  output logic [AW-1:0]          bus_err_addr,
  input  logic                   err_clr
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state_q;
  logic [3:0]      wcnt_q;
  logic            done_q;
  logic            first_q;
  logic [AW-1:0]   prev_ab_q;
  logic            prev_we_q;
  logic [SW-1:0]   sel_q;
  logic            none_q;
  logic            bus_err_q;
  logic [AW-1:0]   bus_err_addr_q;

  logic [SW-1:0]   sel;
  logic            none;
  logic [3:0]      wait_sel;
  logic            new_acc;
  logic            stall;

  // Scan from the top down so the lowest-index hit wins on overlap.
  always_comb begin
    sel  = '0;
    none = 1'b1;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_ab & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) begin
        sel  = SW'(i);
        none = 1'b0;
      end
    end
  end

  assign wait_sel = WAIT[sel*4 +: 4];
  assign new_acc  = first_q | (cpu_ab != prev_ab_q) | (cpu_we_n != prev_we_q);
  assign stall    = (state_q == ST_IDLE) & ~done_q & ~none & (wait_sel != 4'd0) & new_acc;
  assign cpu_rdy  = (state_q == ST_IDLE) & ~stall;

  always_comb begin
    s_cs_n = '1;
    if (!none) s_cs_n[sel] = 1'b0;
  end

  assign s_we_n       = cpu_we_n | ~cpu_rdy | none;
  assign s_wdata      = cpu_do;
  assign cpu_di       = none_q ? UNMAPPED_DATA : s_rdata[sel_q*DW +: DW];
  assign bus_err      = bus_err_q;
  assign bus_err_addr = bus_err_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wcnt_q         <= 4'd0;
      done_q         <= 1'b0;
      first_q        <= 1'b1;
      prev_ab_q      <= '0;
      prev_we_q      <= 1'b1;
      sel_q          <= '0;
      none_q         <= 1'b0;
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= '0;
    end else begin
      first_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The stall cycle in IDLE counts as the first wait cycle.
          if (stall) begin
            if (wait_sel == 4'd1) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              wcnt_q  <= wait_sel - 4'd1;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            done_q  <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (cpu_rdy) begin
        prev_ab_q <= cpu_ab;
        prev_we_q <= cpu_we_n;
        sel_q     <= sel;
        none_q    <= none;
      end

      // A fresh unmapped access coinciding with a clear re-arms the capture.
      if (cpu_rdy && none && (!bus_err_q || err_clr)) begin
        bus_err_q      <= 1'b1;
        bus_err_addr_q <= cpu_ab;
      end else if (err_clr) begin
        bus_err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric with default parameters.
module tb_soc_bus_fabric;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_ab;
  logic        cpu_we_n;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [3:0]  s_cs_n;
  logic        s_we_n;
  logic [7:0]  s_wdata;
  logic [31:0] s_rdata;
  logic        bus_err;
  logic [15:0] bus_err_addr;
  logic        err_clr;

  int n_total;
  int n_pass;

  soc_bus_fabric dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_ab       (cpu_ab),
    .cpu_we_n     (cpu_we_n),
    .cpu_do       (cpu_do),
    .cpu_di       (cpu_di),
    .cpu_rdy      (cpu_rdy),
    .s_cs_n       (s_cs_n),
    .s_we_n       (s_we_n),
    .s_wdata      (s_wdata),
    .s_rdata      (s_rdata),
    .bus_err      (bus_err),
    .bus_err_addr (bus_err_addr),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    reset    = 1'b1;
    cpu_ab   = 16'h0000;
    cpu_we_n = 1'b1;
    cpu_do   = 8'h00;
    err_clr  = 1'b0;
    s_rdata  = {8'h55, 8'h22, 8'h11, 8'hAA};
    tick();
    tick();

    // Reset state, then read 0x0005 (slot 0)
    reset  = 1'b0;
    cpu_ab = 16'h0005;
    #1;
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_err_addr", bus_err_addr, 16'h0000);
    check("rst_cpu_di", cpu_di, 8'hAA);
    check("rd0_cs", s_cs_n, 4'b1110);
    check("rd0_rdy", cpu_rdy, 1'b1);
    check("rd0_we", s_we_n, 1'b1);

    // Read 0xF123 (slot 3)
    tick();
    cpu_ab = 16'hF123;
    #1;
    check("rd0_di", cpu_di, 8'hAA);
    check("rd3_cs", s_cs_n, 4'b0111);
    check("rd3_rdy", cpu_rdy, 1'b1);
    tick();

    // Write 0x1041 (slot 2, two wait states)
    cpu_ab   = 16'h1041;
    cpu_we_n = 1'b0;
    cpu_do   = 8'h3C;
    #1;
    check("rd3_di", cpu_di, 8'h55);
    check("wr_c1_rdy", cpu_rdy, 1'b0);
    check("wr_c1_cs", s_cs_n, 4'b1011);
    check("wr_c1_we", s_we_n, 1'b1);
    tick();
    check("wr_c2_rdy", cpu_rdy, 1'b0);
    check("wr_c2_cs", s_cs_n, 4'b1011);
    check("wr_c2_we", s_we_n, 1'b1);
    tick();
    check("wr_c3_rdy", cpu_rdy, 1'b1);
    check("wr_c3_cs", s_cs_n, 4'b1011);
    check("wr_c3_we", s_we_n, 1'b0);
    check("wr_c3_wdata", s_wdata, 8'h3C);
    tick();

    // Read 0x1000 (slot 1 by masking)
    cpu_ab   = 16'h1000;
    cpu_we_n = 1'b1;
    #1;
    check("wr_after_di", cpu_di, 8'h22);
    check("rd1_cs", s_cs_n, 4'b1101);
    check("rd1_rdy", cpu_rdy, 1'b1);
    check("rd1_we", s_we_n, 1'b1);
    tick();

    // Read 0x1040 (slot 2, stalled)
    cpu_ab = 16'h1040;
    #1;
    check("rd1_di", cpu_di, 8'h11);
    check("rd2_cs", s_cs_n, 4'b1011);
    check("rd2_c1_rdy", cpu_rdy, 1'b0);
    tick();
    check("rd2_c2_rdy", cpu_rdy, 1'b0);
    check("rd2_hold_di", cpu_di, 8'h11);
    tick();
    check("rd2_c3_rdy", cpu_rdy, 1'b1);
    tick();
    // Same address held after completion: not a new access
    check("rd2_repeat_rdy", cpu_rdy, 1'b1);
    check("rd2_di", cpu_di, 8'h22);
    tick();

    // Unmapped read 0x8000
    cpu_ab = 16'h8000;
    #1;
    check("um_cs", s_cs_n, 4'b1111);
    check("um_rdy", cpu_rdy, 1'b1);
    check("um_pre_err", bus_err, 1'b0);
    tick();

    // Unmapped write 0x9000: dropped, address not overwritten
    cpu_ab   = 16'h9000;
    cpu_we_n = 1'b0;
    cpu_do   = 8'h77;
    #1;
    check("um_di", cpu_di, 8'hFF);
    check("um_err", bus_err, 1'b1);
    check("um_err_addr", bus_err_addr, 16'h8000);
    check("um_wr_cs", s_cs_n, 4'b1111);
    check("um_wr_we", s_we_n, 1'b1);
    tick();
    cpu_ab   = 16'h0000;
    cpu_we_n = 1'b1;
    #1;
    check("um2_err", bus_err, 1'b1);
    check("um2_err_addr", bus_err_addr, 16'h8000);
    tick();

    // err_clr alone
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    cpu_ab  = 16'h8000;
    #1;
    check("clr_err", bus_err, 1'b0);
    tick();
    check("recap_err", bus_err, 1'b1);
    check("recap_addr", bus_err_addr, 16'h8000);

    // err_clr coincident with unmapped read of 0xA000
    cpu_ab  = 16'hA000;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("clrcap_err", bus_err, 1'b1);
    check("clrcap_addr", bus_err_addr, 16'hA000);
    check("clrcap_di", cpu_di, 8'hFF);

    // Reset during the first WAIT cycle of a write to 0x1042
    cpu_ab   = 16'h1042;
    cpu_we_n = 1'b0;
    cpu_do   = 8'h5A;
    #1;
    check("rw_c1_rdy", cpu_rdy, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check("rw_c2_rdy", cpu_rdy, 1'b0);
    check("rw_c2_we", s_we_n, 1'b1);
    tick();
    reset    = 1'b0;
    cpu_ab   = 16'h0000;
    cpu_we_n = 1'b1;
    #1;
    check("rw_post_rdy", cpu_rdy, 1'b1);
    check("rw_post_we", s_we_n, 1'b1);
    check("rw_post_err", bus_err, 1'b0);
    check("rw_post_addr", bus_err_addr, 16'h0000);
    check("rw_post_di", cpu_di, 8'hAA);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
